e_digit_uart_tx: RTL and testbench

- Downstream consumer of the spigot-e digit stream.
- Accepts one BCD digit per valid/ready handshake and buffers it in a small FIFO.
- Transmits each digit as an ASCII character on a UART 8N1 line, giving a host "2.71828..." with no extra pins beyond one output.
- Sits between the spigot core digit output and a spare output pin of the tile.

---
 rtl/e_uart_pkg.sv | 20 ++
 rtl/e_digit_fifo.sv | 62 ++++++
 rtl/e_digit_uart_tx.sv | 166 ++++++++++++++++
 tb/tb_e_digit_uart_tx.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e_uart_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// e_uart_pkg: state encoding and ASCII/frame constants for the e-digit UART
// Revision: 1.0
// ------------------------------------------------------------------
package e_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_POINT = 8'h2E;
  localparam int         FRAME_BITS  = 10;

endpackage
`default_nettype wire

// File: rtl/e_digit_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// e_digit_fifo: small power-of-two FIFO of 4-bit BCD digits, no bypass
// Revision: 1.0
// ------------------------------------------------------------------
module e_digit_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [3:0] wdata,
  input  logic       pop,
  output logic [3:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   occ;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (occ == (AW+1)'(FIFO_DEPTH));
  assign empty   = (occ == '0);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/e_digit_uart_tx.sv
`default_nettype none
// ------------------------------------------------------------------
// e_digit_uart_tx: BCD digit stream to ASCII characters on a UART 8N1 line
// Revision: 1.0
// ------------------------------------------------------------------
module e_digit_uart_tx
  import e_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 8,
  parameter int INSERT_POINT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  io_digit,
  input  logic        io_valid,
  output logic        io_ready,
  output logic        io_tx,
  output logic        io_busy,
  output logic [15:0] io_count,
  output logic        io_err
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam int             DATA_BITS = FRAME_BITS - 2;
  localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);

  uart_state_t   state, state_d;
  logic [CW-1:0] baud, baud_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    shreg, shreg_d;
  logic          tx_q, tx_d;
  logic          point_pending;
  logic          point_armed;
  logic [15:0]   count;
  logic          err;

  logic          xfer;
  logic          push_ok;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [3:0]    fifo_rdata;
  logic          baud_last;
  logic          count_inc;
  logic          arm_set;
  logic          point_clr;

  assign io_ready = !fifo_full;
  assign xfer     = io_valid && io_ready;
  assign push_ok  = xfer && (io_digit <= 4'd9);

  e_digit_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .wdata (io_digit),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_last = (baud == BAUD_LAST);

  // tx_d is derived from the current state, so the line lags the FSM by one cycle.
  always_comb begin
    state_d   = state;
    baud_d    = baud + CW'(1);
    bit_d     = bit_idx;
    shreg_d   = shreg;
    tx_d      = 1'b1;
    fifo_pop  = 1'b0;
    count_inc = 1'b0;
    arm_set   = 1'b0;
    point_clr = 1'b0;
    case (state)
      IDLE: begin
        baud_d = '0;
        if (point_armed) begin
          shreg_d   = ASCII_POINT;
          point_clr = 1'b1;
          state_d   = START;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = ASCII_ZERO + {4'd0, fifo_rdata};
          state_d  = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_d = shreg[0];
        if (baud_last) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg[7:1]};
          if (bit_idx == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_d = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d    = '0;
          count_inc = 1'b1;
          arm_set   = point_pending;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      baud          <= '0;
      bit_idx       <= 3'd0;
      shreg         <= 8'd0;
      tx_q          <= 1'b1;
      point_pending <= (INSERT_POINT != 0);
      point_armed   <= 1'b0;
      count         <= 16'd0;
      err           <= 1'b0;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_idx <= bit_d;
      shreg   <= shreg_d;
      tx_q    <= tx_d;
      if (count_inc) begin
        count <= count + 16'd1;
      end
      if (point_clr) begin
        point_pending <= 1'b0;
        point_armed   <= 1'b0;
      end else if (arm_set) begin
        point_armed <= 1'b1;
      end
      if (xfer && (io_digit > 4'd9)) begin
        err <= 1'b1;
      end
    end
  end

  assign io_tx    = tx_q;
  assign io_busy  = (state != IDLE) || !fifo_empty;
  assign io_count = count;
  assign io_err   = err;

endmodule
`default_nettype wire

// File: tb/tb_e_digit_uart_tx.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_e_digit_uart_tx: character-stream model plus UART receiver for e_digit_uart_tx
// Revision: 1.0
// ------------------------------------------------------------------
module tb_e_digit_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  dig  [2];
  logic        vld  [2];
  logic        rdy  [2];
  logic        txs  [2];
  logic        bsy  [2];
  logic [15:0] cnt  [2];
  logic        errs [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rst_last = 1'b0;

  // Model: the character stream the host must see, in order.
  logic [7:0] exp_q [$];
  int         inc_q [$];
  int         exp_count = 0;
  logic       exp_err = 1'b0;
  int         n_pushed = 0;

  // Receiver state for the main instance.
  bit         rx_active = 1'b0;
  int         rx_f = 0;
  logic [7:0] rx_exp = 8'h00;
  logic [9:0] rx_frame = 10'h0;
  logic [7:0] rx_log [$];
  int         falls [$];

  e_digit_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .INSERT_POINT(1)) dut (
    .clk(clk), .reset(reset), .io_digit(dig[0]), .io_valid(vld[0]), .io_ready(rdy[0]),
    .io_tx(txs[0]), .io_busy(bsy[0]), .io_count(cnt[0]), .io_err(errs[0])
  );

  e_digit_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .INSERT_POINT(0)) dut_np (
    .clk(clk), .reset(reset), .io_digit(dig[1]), .io_valid(vld[1]), .io_ready(rdy[1]),
    .io_tx(txs[1]), .io_busy(bsy[1]), .io_count(cnt[1]), .io_err(errs[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  // Model update on each rising edge, from the pre-edge input values.
  initial forever begin
    @(posedge clk);
    cyc++;
    rst_last = reset;
    if (reset) begin
      exp_q.delete();
      inc_q.delete();
      exp_count = 0;
      exp_err   = 1'b0;
      n_pushed  = 0;
      rx_active = 1'b0;
    end else begin
      if (inc_q.size() > 0 && inc_q[0] == cyc) begin
        void'(inc_q.pop_front());
        exp_count = (exp_count + 1) % 65536;
      end
      if (vld[0] === 1'b1 && rdy[0] === 1'b1) begin
        if (dig[0] <= 4'd9) begin
          exp_q.push_back({4'h3, dig[0]});
          if (n_pushed == 0) exp_q.push_back(8'h2E);
          n_pushed++;
        end else begin
          exp_err = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare: line level against the expected frame, count and error flag.
  initial forever begin
    int         off;
    logic [3:0] ki;
    logic [9:0] fr;
    @(negedge clk);
    if (cyc == 0) continue;
    if (rst_last) begin
      chk("reset_tx", 32'(txs[0]), 1);
      chk("reset_ready", 32'(rdy[0]), 1);
      chk("reset_busy", 32'(bsy[0]), 0);
    end else begin
      if (!rx_active) begin
        if (txs[0] === 1'b0) begin
          rx_f = cyc;
          rx_active = 1'b1;
          falls.push_back(cyc);
          inc_q.push_back(cyc + FRAME - 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame at edge %0d: start bit seen, required idle line", cyc);
            rx_exp = 8'hFF;
          end else begin
            rx_exp = exp_q.pop_front();
          end
        end else begin
          chk("idle_tx", 32'(txs[0]), 1);
        end
      end
      if (rx_active) begin
        off = cyc - rx_f;
        ki  = 4'(off / CPB);
        fr  = {1'b1, rx_exp, 1'b0};
        chk("frame_bit", 32'(txs[0]), 32'(fr[ki]));
        if (off % CPB == CPB / 2) rx_frame[ki] = txs[0];
        if (off <= FRAME - 2) chk("busy_in_frame", 32'(bsy[0]), 1);
        if (off == FRAME - 1) begin
          chk("char", 32'(rx_frame[8:1]), 32'(rx_exp));
          rx_log.push_back(rx_frame[8:1]);
          rx_active = 1'b0;
        end
      end
    end
    chk("count", 32'(cnt[0]), exp_count);
    chk("err", 32'(errs[0]), 32'(exp_err));
  end

  task automatic push(input int which, input logic [3:0] d, output int t, output int w);
    logic r;
    dig[which] = d;
    vld[which] = 1'b1;
    w = 0;
    do begin
      @(posedge clk);
      r = rdy[which];
      w++;
    end while (r !== 1'b1 && w < 200);
    #1;
    t = cyc;
    chk("push_accept", 32'(r), 1);
  endtask

  task automatic drain();
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      done = (exp_q.size() == 0) && !rx_active && (bsy[0] === 1'b0);
    end
    chk("drain_done", 32'(done), 1);
    chk("drain_busy", 32'(bsy[0]), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic recv1(output logic [7:0] b, output int f);
    int n = 0;
    b = 8'h00;
    f = -1;
    do begin
      @(negedge clk);
      n++;
    end while (txs[1] !== 1'b0 && n < 400);
    chk("np_start_seen", 32'(txs[1] === 1'b0), 1);
    if (txs[1] === 1'b0) begin
      f = cyc;
      repeat (CPB / 2) @(negedge clk);
      chk("np_start_bit", 32'(txs[1]), 0);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        b = {txs[1], b[7:1]};
      end
      repeat (CPB) @(negedge clk);
      chk("np_stop_bit", 32'(txs[1]), 1);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: run still active at edge %0d, required finished", cyc);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int         t, w, t_first, first_wait, nv, n, lows, f0, f1;
    logic       any_bad;
    logic [3:0] d;
    logic [7:0] b0, b1;
    logic [7:0] exp2 [5];
    dig[0] = 4'd0; dig[1] = 4'd0; vld[0] = 1'b0; vld[1] = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Quiet line after reset.
    repeat (100) begin
      @(negedge clk);
      chk("idle_ready", 32'(rdy[0]), 1);
      chk("idle_busy", 32'(bsy[0]), 0);
      chk("idle_line", 32'(txs[0]), 1);
    end

    // 2,7,1,8 back-to-back: "2.718".
    rx_log.delete();
    falls.delete();
    push(0, 4'd2, t_first, w);
    push(0, 4'd7, t, w);
    push(0, 4'd1, t, w);
    push(0, 4'd8, t, w);
    vld[0] = 1'b0;
    drain();
    chk("first_fall_latency", 32'(falls.size() > 0 ? falls[0] : -1), 32'(t_first + 2));
    exp2 = '{8'h32, 8'h2E, 8'h37, 8'h31, 8'h38};
    chk("t2_nchars", 32'(rx_log.size()), 5);
    for (int i = 0; i < 5; i++)
      chk("t2_byte", 32'(i < rx_log.size() ? rx_log[i] : 8'h00), 32'(exp2[i]));
    chk("t2_count", 32'(cnt[0]), 5);

    // Valid held high with 0..9 cycling: back-pressure after 4 stored plus 1 in flight.
    rx_log.delete();
    first_wait = -1;
    for (int i = 0; i < 20; i++) begin
      push(0, 4'(i % 10), t, w);
      if (w > 1 && first_wait < 0) first_wait = i;
    end
    vld[0] = 1'b0;
    drain();
    chk("hold_ready_drop", 32'(first_wait), 5);
    chk("hold_nchars", 32'(rx_log.size()), 20);
    for (int i = 0; i < 20 && i < rx_log.size(); i++)
      chk("hold_byte", 32'(rx_log[i]), 32'({4'h3, 4'(i % 10)}));

    // Invalid digit 12 then 5.
    do_reset();
    rx_log.delete();
    push(0, 4'd12, t, w);
    push(0, 4'd5, t, w);
    vld[0] = 1'b0;
    @(negedge clk);
    chk("err_set", 32'(errs[0]), 1);
    drain();
    chk("err_sticky", 32'(errs[0]), 1);
    chk("err_nchars", 32'(rx_log.size()), 2);
    chk("err_byte0", 32'(rx_log.size() > 0 ? rx_log[0] : 8'h00), 32'h35);
    chk("err_byte1", 32'(rx_log.size() > 1 ? rx_log[1] : 8'h00), 32'h2E);
    chk("err_count", 32'(cnt[0]), 2);

    // Reset during data bit 3 of '7'.
    do_reset();
    chk("err_cleared", 32'(errs[0]), 0);
    rx_log.delete();
    push(0, 4'd7, t, w);
    vld[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rx_active && (cyc - rx_f) == 16) && n < 200);
    chk("rst_reach_bit3", 32'(n < 200), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_tx_high", 32'(txs[0]), 1);
    chk("rst_ready", 32'(rdy[0]), 1);
    chk("rst_busy", 32'(bsy[0]), 0);
    chk("rst_count", 32'(cnt[0]), 0);
    push(0, 4'd3, t, w);
    vld[0] = 1'b0;
    drain();
    chk("rst_nchars", 32'(rx_log.size()), 2);
    chk("rst_byte0", 32'(rx_log.size() > 0 ? rx_log[0] : 8'h00), 32'h33);
    chk("rst_byte1", 32'(rx_log.size() > 1 ? rx_log[1] : 8'h00), 32'h2E);
    chk("rst_count2", 32'(cnt[0]), 2);

    // Random digits (including invalid codes) with random gaps.
    do_reset();
    nv = 0;
    any_bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      d = 4'($urandom_range(0, 15));
      if (d <= 4'd9) nv++;
      else any_bad = 1'b1;
      push(0, d, t, w);
      n = int'($urandom_range(0, 3));
      if (n > 0) begin
        vld[0] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
      end
    end
    vld[0] = 1'b0;
    drain();
    chk("rand_count", 32'(cnt[0]), 32'(nv + (nv > 0 ? 1 : 0)));
    chk("rand_err", 32'(errs[0]), 32'(any_bad));

    // Instance without point insertion: 2,7 -> "27", start-to-start 41 cycles.
    fork
      begin
        push(1, 4'd2, t, w);
        push(1, 4'd7, t, w);
        vld[1] = 1'b0;
      end
      begin
        recv1(b0, f0);
        recv1(b1, f1);
      end
    join
    chk("np_byte0", 32'(b0), 32'h32);
    chk("np_byte1", 32'(b1), 32'h37);
    chk("np_gap", 32'(f1 - f0), 41);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (txs[1] !== 1'b1) lows++;
    end
    chk("np_no_extra", 32'(lows), 0);
    chk("np_count", 32'(cnt[1]), 2);
    chk("np_busy", 32'(bsy[1]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
